// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit full adder cell
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term shared by sum and carry
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH-bit ripple-carry adder with combinational and registered results
module full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic [WIDTH-1:0] Sum_q,
    output logic             C_out_q
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = C_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_d[i]),
            .cout (carry[i+1])
        );
    end

    assign cout_d = carry[WIDTH];
    assign Sum    = sum_d;
    assign C_out  = cout_d;

    // Reset clears only the pipeline copy; the combinational path never sees it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum_q   = sum_q;
    assign C_out_q = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder at WIDTH=1 and WIDTH=4
`timescale 1ns/1ps
module tb_full_adder;

    typedef struct {
        logic       a;
        logic       b;
        logic       cin;
        logic [1:0] exp;
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp;
    } vec4_t;

    logic       clk1, rst1, a1, b1, c1, s1, co1, sq1, coq1;
    logic       clk4, rst4, c4, co4, coq4;
    logic [3:0] a4, b4, s4, sq4;

    int checks;
    int fails;

    vec1_t tab1 [8];
    vec4_t tab4 [4];

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk1), .rst(rst1), .A(a1), .B(b1), .C_in(c1),
        .Sum(s1), .C_out(co1), .Sum_q(sq1), .C_out_q(coq1)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk4), .rst(rst4), .A(a4), .B(b4), .C_in(c4),
        .Sum(s4), .C_out(co4), .Sum_q(sq4), .C_out_q(coq4)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse1();
        clk1 = 1'b1;
        #5;
        clk1 = 1'b0;
        #5;
    endtask

    task automatic pulse4();
        clk4 = 1'b1;
        #5;
        clk4 = 1'b0;
        #5;
    endtask

    initial begin
        logic [4:0] exp5;
        logic [4:0] prev5;

        checks = 0;
        fails  = 0;
        clk1 = 1'b0; rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        clk4 = 1'b0; rst4 = 1'b1; a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

        tab1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        tab1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        tab1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        tab1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        tab1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        tab1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        tab1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        tab1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        tab4[0] = '{4'hF, 4'h0, 1'b1, 5'h10};
        tab4[1] = '{4'h7, 4'h8, 1'b0, 5'h0F};
        tab4[2] = '{4'hF, 4'hF, 1'b1, 5'h1F};
        tab4[3] = '{4'h0, 4'h0, 1'b0, 5'h00};

        #1;
        chk("reset_w1", 8'({coq1, sq1}), 8'h00);
        chk("reset_w4", 8'({coq4, sq4}), 8'h00);

        // Truth table with no clock activity
        for (int i = 0; i < 8; i++) begin
            a1 = tab1[i].a; b1 = tab1[i].b; c1 = tab1[i].cin;
            #1;
            chk($sformatf("truth_%0d", i), 8'({co1, s1}), 8'(tab1[i].exp));
            #1;
        end

        // Combinational result while reset is held and clock is low
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        #0.1;
        chk("comb_in_reset", 8'({co1, s1}), 8'b10);
        chk("regs_in_reset", 8'({coq1, sq1}), 8'h00);
        #1;

        // Registered path: prior value held until the edge
        rst1 = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        #2;
        pulse1();
        chk("reg_111", 8'({coq1, sq1}), 8'b11);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        #1;
        chk("reg_hold", 8'({coq1, sq1}), 8'b11);
        pulse1();
        chk("reg_101", 8'({coq1, sq1}), 8'b10);

        // Asynchronous reset between edges
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        #2;
        pulse1();
        chk("reg_100", 8'({coq1, sq1}), 8'b01);
        #2;
        rst1 = 1'b1;
        #0.5;
        chk("async_rst", 8'({coq1, sq1}), 8'h00);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        pulse1();
        chk("rst_held_1", 8'({coq1, sq1}), 8'h00);
        pulse1();
        chk("rst_held_2", 8'({coq1, sq1}), 8'h00);
        chk("comb_rst_held", 8'({co1, s1}), 8'b11);
        rst1 = 1'b0;
        #2;
        pulse1();
        chk("rst_release", 8'({coq1, sq1}), 8'b11);

        // WIDTH=4 directed carry cases
        for (int i = 0; i < 4; i++) begin
            a4 = tab4[i].a; b4 = tab4[i].b; c4 = tab4[i].cin;
            #1;
            chk($sformatf("w4_dir_%0d", i), 8'({co4, s4}), 8'(tab4[i].exp));
            #1;
        end

        // WIDTH=4 random with one-cycle registered shadow
        rst4 = 1'b0;
        prev5 = 5'h00;
        for (int i = 0; i < 200; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            c4 = 1'($urandom_range(0, 1));
            exp5 = {1'b0, a4} + {1'b0, b4} + {4'b0000, c4};
            #1;
            chk("w4_rand_comb", 8'({co4, s4}), 8'(exp5));
            chk("w4_rand_prev", 8'({coq4, sq4}), 8'(prev5));
            #1;
            pulse4();
            chk("w4_rand_reg", 8'({coq4, sq4}), 8'(exp5));
            prev5 = exp5;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
